// File: rtl/io_bridge_pkg.sv
// ----------------------------------------------------------------------------
// io_bridge_pkg
// Shared memory-map and defines package for the CPU IO bridge.
//   IO_REGION_HI      : upper address half that selects the IO region
//   *_IDX             : slave index assignments on the IO bus
//   io_bridge_state_t : bridge transaction FSM states
// ----------------------------------------------------------------------------
package io_bridge_pkg;

    // Memory map: the IO region is the top 64 KiB of the address space.
    localparam logic [15:0] IO_REGION_HI = 16'hFFFF;

    // Slave index assignments (value of the 3-bit slave index field).
    localparam logic [2:0] UART_IDX = 3'd1;

    // Bridge transaction FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } io_bridge_state_t;

endpackage

// File: rtl/io_bridge.sv
// ----------------------------------------------------------------------------
// io_bridge
// Converts single CPU load/store requests into one-cycle strobes on a simple
// IO slave bus and returns a response (load data or decode error).
//
// Ports
//   clk, rst           : clock, synchronous active-low reset
//   io_req_*           : CPU request (valid/ready, we, addr, wdata)
//   io_rsp_*           : CPU response (valid/ready, rdata, err)
//   io_bus_s_*         : slave bus (one-hot cs, rd/wr strobes, address, data)
//   slave_rd_data      : per-slave read data, registered by the slave
//
// Transaction: IDLE (accept) -> ACCESS (strobe) -> CAPTURE (sample slave
// data, which is valid the cycle after the strobe) -> RESP (hold until the
// CPU takes it).
// ----------------------------------------------------------------------------
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_LSB    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            io_req_valid,
    input  logic                            io_req_we,
    input  logic [31:0]                     io_req_addr,
    input  logic [31:0]                     io_req_wdata,
    output logic                            io_req_ready,
    output logic                            io_rsp_valid,
    input  logic                            io_rsp_ready,
    output logic [31:0]                     io_rsp_rdata,
    output logic                            io_rsp_err,
    output logic [NUM_SLAVES-1:0]           io_bus_s_cs,
    output logic                            io_bus_s_rd_en,
    output logic                            io_bus_s_wr_en,
    output logic [31:0]                     io_bus_s_address,
    output logic [31:0]                     io_bus_s_wr_data,
    input  logic [NUM_SLAVES-1:0][31:0]     slave_rd_data
);

    io_bridge_state_t        state_reg;
    logic                    we_reg;
    logic                    mapped_reg;
    logic [2:0]              idx_reg;
    logic [31:0]             addr_reg;
    logic [31:0]             wdata_reg;
    logic [NUM_SLAVES-1:0]   cs_reg;
    logic                    rd_en_reg;
    logic                    wr_en_reg;
    logic                    rsp_valid_reg;
    logic [31:0]             rsp_rdata_reg;
    logic                    rsp_err_reg;

    // Request decode, evaluated on the incoming address.
    logic [2:0]              req_idx;
    logic                    req_mapped;
    logic [NUM_SLAVES-1:0]   req_cs;

    assign req_idx    = io_req_addr[SEL_LSB+2:SEL_LSB];
    assign req_mapped = (io_req_addr[31:16] == IO_REGION_HI) &&
                        (32'(req_idx) < NUM_SLAVES);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cs_dec
            assign req_cs[gi] = req_mapped && (req_idx == 3'(gi));
        end
    endgenerate

    // Read mux over the captured slave index.
    logic [31:0] sel_rdata;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_reg == 3'(i)) begin
                sel_rdata = slave_rd_data[i];
            end
        end
    end

    // Ready is gated by rst so it is low for the whole reset period and high
    // in the very first cycle after release.
    assign io_req_ready     = rst && (state_reg == IDLE);
    assign io_rsp_valid     = rsp_valid_reg;
    assign io_rsp_rdata     = rsp_rdata_reg;
    assign io_rsp_err       = rsp_err_reg;
    assign io_bus_s_cs      = cs_reg;
    assign io_bus_s_rd_en   = rd_en_reg;
    assign io_bus_s_wr_en   = wr_en_reg;
    assign io_bus_s_address = addr_reg;
    assign io_bus_s_wr_data = wdata_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            mapped_reg    <= 1'b0;
            idx_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cs_reg        <= '0;
            rd_en_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io_req_valid) begin
                        we_reg     <= io_req_we;
                        addr_reg   <= io_req_addr;
                        wdata_reg  <= io_req_wdata;
                        idx_reg    <= req_idx;
                        mapped_reg <= req_mapped;
                        // Strobes are launched here so they are visible for
                        // exactly the ACCESS cycle.
                        cs_reg     <= req_cs;
                        rd_en_reg  <= req_mapped && !io_req_we;
                        wr_en_reg  <= req_mapped && io_req_we;
                        state_reg  <= ACCESS;
                    end
                end
                ACCESS: begin
                    cs_reg    <= '0;
                    rd_en_reg <= 1'b0;
                    wr_en_reg <= 1'b0;
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_rdata_reg <= (mapped_reg && !we_reg) ? sel_rdata : 32'd0;
                    rsp_err_reg   <= !mapped_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (io_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// ----------------------------------------------------------------------------
// tb_io_bridge
// Self-checking bench for io_bridge: reset state, a table of directed
// transactions, randomized transactions against a transaction-level model,
// response back-pressure with a queued second request, and reset abort.
// ----------------------------------------------------------------------------
module tb_io_bridge;
    import io_bridge_pkg::*;

    localparam int NS = 4;

    logic               clk;
    logic               rst;
    logic               io_req_valid;
    logic               io_req_we;
    logic [31:0]        io_req_addr;
    logic [31:0]        io_req_wdata;
    logic               io_req_ready;
    logic               io_rsp_valid;
    logic               io_rsp_ready;
    logic [31:0]        io_rsp_rdata;
    logic               io_rsp_err;
    logic [NS-1:0]      io_bus_s_cs;
    logic               io_bus_s_rd_en;
    logic               io_bus_s_wr_en;
    logic [31:0]        io_bus_s_address;
    logic [31:0]        io_bus_s_wr_data;
    logic [NS-1:0][31:0] slave_rd_data;

    io_bridge #(.NUM_SLAVES(NS), .SEL_LSB(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .io_req_valid     (io_req_valid),
        .io_req_we        (io_req_we),
        .io_req_addr      (io_req_addr),
        .io_req_wdata     (io_req_wdata),
        .io_req_ready     (io_req_ready),
        .io_rsp_valid     (io_rsp_valid),
        .io_rsp_ready     (io_rsp_ready),
        .io_rsp_rdata     (io_rsp_rdata),
        .io_rsp_err       (io_rsp_err),
        .io_bus_s_cs      (io_bus_s_cs),
        .io_bus_s_rd_en   (io_bus_s_rd_en),
        .io_bus_s_wr_en   (io_bus_s_wr_en),
        .io_bus_s_address (io_bus_s_address),
        .io_bus_s_wr_data (io_bus_s_wr_data),
        .slave_rd_data    (slave_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h1111_0000;
            1:       return 32'h0000_0005;
            2:       return 32'h2222_2222;
            default: return 32'h3333_3333;
        endcase
    endfunction

    // Slave models: one register each, read data registered one cycle after
    // the read strobe, garbage at all other times.
    logic [31:0] slave_mem [NS];
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst) slave_mem[i] <= init_val(i);
            else if (io_bus_s_cs[i] && io_bus_s_wr_en) slave_mem[i] <= io_bus_s_wr_data;
            if (io_bus_s_cs[i] && io_bus_s_rd_en) slave_rd_data[i] <= slave_mem[i];
            else slave_rd_data[i] <= 32'hBAD0_0000 | 32'(i);
        end
    end

    // Transaction-level reference: contents each slave should hold.
    logic [31:0] ref_mem [NS];

    task automatic ref_reset();
        for (int i = 0; i < NS; i++) ref_mem[i] = init_val(i);
    endtask

    function automatic logic model_mapped(input logic [31:0] a);
        return (a[31:16] == 16'hFFFF) && (int'(a[10:8]) < NS);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction with expected results; hold = cycles rsp_ready
    // stays low once the response is up.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic [NS-1:0] exp_cs, input int hold);
        int waitc, rd_n, wr_n, cs_n, lat;
        logic [NS-1:0] cs_k1;
        logic [31:0] addr_k1, wd_k1, r0;
        logic e0, stable;
        @(negedge clk);
        io_req_valid = 1'b1; io_req_we = we; io_req_addr = addr; io_req_wdata = wdata;
        io_rsp_ready = 1'b0;
        waitc = 0;
        while (!io_req_ready && waitc < 20) begin @(negedge clk); waitc++; end
        check({tag, " accept"}, 32'(waitc < 20), 32'd1);
        if (waitc >= 20) begin io_req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        io_req_valid = 1'b0;
        rd_n = 0; wr_n = 0; cs_n = 0; lat = 0;
        cs_k1 = '0; addr_k1 = '0; wd_k1 = '0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin cs_k1 = io_bus_s_cs; addr_k1 = io_bus_s_address; wd_k1 = io_bus_s_wr_data; end
            if (io_bus_s_rd_en) rd_n++;
            if (io_bus_s_wr_en) wr_n++;
            if (io_bus_s_cs != '0) cs_n++;
            if (io_rsp_valid) begin lat = k; break; end
            @(negedge clk);
        end
        check({tag, " cs"},      32'(cs_k1), 32'(exp_cs));
        check({tag, " cs_cyc"},  32'(cs_n), 32'(exp_cs != '0));
        check({tag, " rd_cyc"},  32'(rd_n), 32'((exp_cs != '0) && !we));
        check({tag, " wr_cyc"},  32'(wr_n), 32'((exp_cs != '0) && we));
        check({tag, " address"}, addr_k1, addr);
        check({tag, " wr_data"}, wd_k1, wdata);
        check({tag, " latency"}, 32'(lat), 32'd3);
        if (lat == 0) return;
        r0 = io_rsp_rdata; e0 = io_rsp_err; stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!io_rsp_valid || io_rsp_rdata !== r0 || io_rsp_err !== e0 || io_req_ready) stable = 1'b0;
        end
        check({tag, " stable"}, 32'(stable), 32'd1);
        check({tag, " rdata"},  io_rsp_rdata, exp_rdata);
        check({tag, " err"},    32'(io_rsp_err), 32'(exp_err));
        io_rsp_ready = 1'b1;
        @(negedge clk);
        io_rsp_ready = 1'b0;
        check({tag, " rsp_drop"}, 32'(io_rsp_valid), 32'd0);
        check({tag, " ready"},    32'(io_req_ready), 32'd1);
        $display("txn %s we=%0d addr=%h wdata=%h rdata=%h err=%0d", tag, we, addr, wdata, r0, e0);
    endtask

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic [NS-1:0] exp_cs;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd, exp_r, r0;
        logic we, mapped, stable;
        logic [2:0] idx;
        logic [NS-1:0] ecs;
        int w, seen_rsp, seen_strobe;

        vecs[0]  = '{1'b0, 32'hFFFF_0104, 32'h0,         32'h0000_0005, 1'b0, 4'b0010};
        vecs[1]  = '{1'b1, 32'hFFFF_0100, 32'h0000_0041, 32'h0,         1'b0, 4'b0010};
        vecs[2]  = '{1'b0, 32'h1000_0000, 32'h0,         32'h0,         1'b1, 4'b0000};
        vecs[3]  = '{1'b0, 32'hFFFF_0700, 32'h0,         32'h0,         1'b1, 4'b0000};
        vecs[4]  = '{1'b1, 32'hFFFF_0700, 32'h0000_DEAD, 32'h0,         1'b1, 4'b0000};
        vecs[5]  = '{1'b0, 32'hFFFF_0104, 32'h0,         32'h0000_0041, 1'b0, 4'b0010};
        vecs[6]  = '{1'b0, 32'hFFFF_0000, 32'h0,         32'h1111_0000, 1'b0, 4'b0001};
        vecs[7]  = '{1'b0, 32'hFFFF_03FC, 32'h0,         32'h3333_3333, 1'b0, 4'b1000};
        vecs[8]  = '{1'b0, 32'hFFFE_0200, 32'h0,         32'h0,         1'b1, 4'b0000};
        vecs[9]  = '{1'b1, 32'hFFFF_0210, 32'h0000_CAFE, 32'h0,         1'b0, 4'b0100};
        vecs[10] = '{1'b0, 32'hFFFF_0200, 32'h0,         32'h0000_CAFE, 1'b0, 4'b0100};

        rst = 1'b0; io_req_valid = 1'b0; io_req_we = 1'b0; io_req_addr = '0;
        io_req_wdata = '0; io_rsp_ready = 1'b0;
        ref_reset();

        // Reset state, with a request pending that must be ignored.
        repeat (3) @(negedge clk);
        io_req_valid = 1'b1; io_req_addr = 32'hFFFF_0104;
        @(negedge clk);
        check("rst ready",     32'(io_req_ready), 32'd0);
        check("rst rsp_valid", 32'(io_rsp_valid), 32'd0);
        check("rst err",       32'(io_rsp_err), 32'd0);
        check("rst rdata",     io_rsp_rdata, 32'd0);
        check("rst cs",        32'(io_bus_s_cs), 32'd0);
        check("rst strobes",   32'({io_bus_s_rd_en, io_bus_s_wr_en}), 32'd0);
        check("rst address",   io_bus_s_address, 32'd0);
        check("rst wr_data",   io_bus_s_wr_data, 32'd0);
        io_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("release ready", 32'(io_req_ready), 32'd1);

        check("uart idx", 32'(UART_IDX), 32'd1);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cs, i % 3);
            if (model_mapped(vecs[i].addr) && vecs[i].we) ref_mem[vecs[i].addr[10:8]] = vecs[i].wdata;
        end

        // Back-pressure: response held 5 cycles while a second request waits.
        @(negedge clk);
        io_req_valid = 1'b1; io_req_we = 1'b0; io_req_addr = 32'hFFFF_0200; io_req_wdata = '0;
        check("bp ready0", 32'(io_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        io_req_we = 1'b1; io_req_addr = 32'hFFFF_0300; io_req_wdata = 32'h0000_5A5A;
        w = 1;
        while (!io_rsp_valid && w < 10) begin @(negedge clk); w++; end
        check("bp latency", 32'(w), 32'd3);
        r0 = io_rsp_rdata; stable = 1'b1;
        for (int h = 0; h < 5; h++) begin
            if (!io_rsp_valid || io_rsp_rdata !== r0 || io_req_ready || io_bus_s_wr_en) stable = 1'b0;
            @(negedge clk);
        end
        check("bp stable", 32'(stable), 32'd1);
        check("bp rdata",  io_rsp_rdata, ref_mem[2]);
        io_rsp_ready = 1'b1;
        @(negedge clk);
        io_rsp_ready = 1'b0;
        check("bp rsp_drop", 32'(io_rsp_valid), 32'd0);
        check("bp ready1",   32'(io_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        io_req_valid = 1'b0;
        check("bp2 wr_en", 32'(io_bus_s_wr_en), 32'd1);
        check("bp2 cs",    32'(io_bus_s_cs), 32'b1000);
        w = 1;
        while (!io_rsp_valid && w < 10) begin @(negedge clk); w++; end
        check("bp2 latency", 32'(w), 32'd3);
        check("bp2 rdata",   io_rsp_rdata, 32'd0);
        check("bp2 err",     32'(io_rsp_err), 32'd0);
        io_rsp_ready = 1'b1;
        @(negedge clk);
        io_rsp_ready = 1'b0;
        ref_mem[3] = 32'h0000_5A5A;
        $display("txn bp load FFFF0200 rdata=%h then store FFFF0300 5a5a", r0);

        // Reset during ACCESS aborts the transaction.
        @(negedge clk);
        io_req_valid = 1'b1; io_req_we = 1'b0; io_req_addr = 32'hFFFF_0104;
        @(posedge clk);
        @(negedge clk);
        io_req_valid = 1'b0;
        check("abort strobe_on", 32'(io_bus_s_rd_en), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort rd_en",   32'(io_bus_s_rd_en), 32'd0);
        check("abort cs",      32'(io_bus_s_cs), 32'd0);
        check("abort ready",   32'(io_req_ready), 32'd0);
        check("abort address", io_bus_s_address, 32'd0);
        rst = 1'b1;
        ref_reset();
        #1;
        check("abort release ready", 32'(io_req_ready), 32'd1);
        seen_rsp = 0; seen_strobe = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (io_rsp_valid) seen_rsp++;
            if (io_bus_s_rd_en || io_bus_s_wr_en) seen_strobe++;
        end
        check("abort no_rsp",    32'(seen_rsp), 32'd0);
        check("abort no_strobe", 32'(seen_strobe), 32'd0);
        run_txn("post_abort", 1'b0, 32'hFFFF_0104, 32'h0, 32'h0000_0005, 1'b0, 4'b0010, 1);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = {(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF),
                  5'($urandom), 3'($urandom_range(0, 7)), 8'($urandom)};
            wd = $urandom;
            mapped = model_mapped(a);
            idx = a[10:8];
            exp_r = 32'd0;
            ecs = '0;
            if (mapped) begin
                ecs = NS'(1) << idx;
                if (!we) exp_r = ref_mem[idx];
            end
            run_txn($sformatf("rnd%0d", n), we, a, wd, exp_r, !mapped, ecs, int'($urandom_range(0, 3)));
            if (mapped && we) ref_mem[idx] = wd;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
